// File: rtl/geofence_feeder.sv
// Point-stream front end for geofence: buffers 7-point objects in two ping-pong
// banks and replays them on the edges geofence samples, gating it via gf_hold.
module geofence_feeder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       gf_hold,
  input  logic       gf_valid,
  output logic [7:0] obj_cnt,
  output logic       err
);
  localparam int unsigned NPTS = 7;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } point_t;

  typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;

  point_t     bank [2][NPTS];
  logic [1:0] full;
  logic       wr_bank, rd_bank;
  logic [2:0] wr_idx, rd_idx;
  state_t     state;
  logic       accept;
  point_t     rd_pt, p0;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid & in_ready;
  assign rd_pt    = bank[rd_bank][rd_idx];
  assign p0       = bank[rd_bank][0];

  // Point storage carries no reset; the full flags alone say what is valid.
  always_ff @(posedge clk)
    if (accept) bank[wr_bank][wr_idx] <= point_t'{x: in_x, y: in_y};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      state   <= HOLD;
      gf_hold <= 1'b1;
      X       <= '0;
      Y       <= '0;
      obj_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_idx == 3'd6) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end

      // The bank being filled is never the full bank being read, so the
      // set above and the clear below never target the same flag.
      case (state)
        HOLD: begin
          if (gf_valid) err <= 1'b1;
          if (full[rd_bank]) begin
            gf_hold <= 1'b0;
            X       <= p0.x;
            Y       <= p0.y;
            rd_idx  <= 3'd1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (gf_valid) err <= 1'b1;
          X <= rd_pt.x;
          Y <= rd_pt.y;
          if (rd_idx == 3'd6) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            rd_idx        <= '0;
            state         <= WAIT;
          end else begin
            rd_idx <= rd_idx + 3'd1;
          end
        end
        WAIT: begin
          if (gf_valid) begin
            obj_cnt <= obj_cnt + 8'd1;
            // Decide on the pre-edge flag: a bank completing this same edge waits one cycle in HOLD.
            if (full[rd_bank]) begin
              X      <= p0.x;
              Y      <= p0.y;
              rd_idx <= 3'd1;
              state  <= STREAM;
            end else begin
              gf_hold <= 1'b1;
              state   <= HOLD;
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_geofence_feeder.sv
// Random/directed bench for geofence_feeder with a behavioural geofence that
// samples X/Y on its contract edges and a queue scoreboard of accepted points.
module tb_geofence_feeder;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, gf_hold, gf_valid, err;
  logic [9:0] in_x, in_y, X, Y;
  logic [7:0] obj_cnt;

  always #5 clk = ~clk;

  geofence_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .X(X), .Y(Y), .gf_hold(gf_hold),
    .gf_valid(gf_valid), .obj_cnt(obj_cnt), .err(err)
  );

  int vectors = 0, miscompares = 0;

  logic [19:0] src[$];
  logic [19:0] exp_q[$];
  logic [19:0] fence_obj[7];
  logic [19:0] last_pt = '0;
  int gap_pct = 0, lat_max = 0;
  int cnt = 0, lat = 0, acc_done = 0, freed = 0, exp_obj = 0;
  bit pend_acc = 0, avail = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [19:0] pt(input int x, input int y);
    return {x[9:0], y[9:0]};
  endfunction

  // One cycle: at the falling edge, play geofence's side of the contract,
  // check the observable state, then drive the next upstream point.
  task automatic step();
    int full_banks;
    @(negedge clk);
    if (pend_acc) acc_done++;
    pend_acc = 1'b0;
    if (gf_valid) begin
      gf_valid = 1'b0;
      exp_obj++;
      cnt = 0;
      chk("zero_bubble", gf_hold, !avail);
    end else if (cnt > 0) begin
      chk("hold_busy", gf_hold, 0);
    end
    if (!gf_hold) begin
      if (cnt < 7) begin
        if (exp_q.size() == 0) begin
          chk("underflow", 1, 0);
        end else begin
          last_pt = exp_q.pop_front();
          chk($sformatf("pt%0d", cnt), {X, Y}, last_pt);
        end
        if (cnt == 6) freed++;
        cnt++;
        if (cnt == 7) lat = $urandom_range(lat_max, 0);
      end else if (lat > 0) begin
        lat--;
      end else begin
        gf_valid = 1'b1;
        avail = (acc_done / 7 - freed) > 0;
      end
    end else begin
      cnt = 0;
    end
    full_banks = acc_done / 7 - freed;
    chk("in_ready", in_ready, full_banks < 2);
    chk("obj_cnt", obj_cnt, exp_obj % 256);
    chk("err", err, exp_err);
    if (src.size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
      in_valid = 1'b1;
      {in_x, in_y} = src[0];
      if (in_ready) begin
        exp_q.push_back(src.pop_front());
        pend_acc = 1'b1;
      end
    end else begin
      in_valid = 1'b0;
      {in_x, in_y} = 20'($urandom);
    end
  endtask

  task automatic push_obj(input logic [19:0] rx);
    src.push_back(rx);
    for (int i = 1; i < 7; i++) src.push_back(fence_obj[i]);
  endtask

  task automatic run_until_obj(input int n);
    int budget = n * 30 + 200;
    while (exp_obj < n && budget > 0) begin
      step();
      budget--;
    end
    chk("obj_timeout", exp_obj >= n, 1);
    chk("drained", exp_q.size() + src.size(), 0);
  endtask

  // Feeds one object into an idle feeder and checks the release edge.
  task automatic feed_release(input logic [19:0] rx);
    int budget = 200;
    push_obj(rx);
    while (src.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("feed_timeout", src.size(), 0);
    step();
    chk("hold_pre", gf_hold, 1);
    step();
    chk("hold_rel", gf_hold, 0);
  endtask

  initial begin
    fence_obj[0] = pt(100, 100);
    fence_obj[1] = pt(50, 50);
    fence_obj[2] = pt(150, 50);
    fence_obj[3] = pt(200, 100);
    fence_obj[4] = pt(150, 150);
    fence_obj[5] = pt(50, 150);
    fence_obj[6] = pt(0, 100);

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; gf_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", gf_hold, 1);
    chk("rst_xy", {X, Y}, 0);
    chk("rst_obj", obj_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) reset = 1'b0;

    // single object, no gaps
    feed_release(fence_obj[0]);
    run_until_obj(1);

    // two and three objects back to back
    lat_max = 3;
    push_obj(fence_obj[0]);
    push_obj(pt(300, 300));
    run_until_obj(3);
    push_obj(pt(11, 22));
    push_obj(pt(33, 44));
    push_obj(pt(55, 66));
    run_until_obj(6);

    // idle gap: hold stays up, X/Y frozen on the last vertex
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle_hold", gf_hold, 1);
      chk("idle_xy", {X, Y}, last_pt);
    end
    feed_release(pt(7, 9));
    run_until_obj(7);

    // random points, bursty input, slow geofence; obj_cnt wraps
    gap_pct = 25;
    lat_max = 12;
    for (int i = 0; i < 260 * 7; i++) src.push_back(20'($urandom));
    run_until_obj(267);

    // reset mid-stream with a partial second bank
    gap_pct = 0;
    for (int i = 0; i < 10; i++) src.push_back(20'($urandom));
    begin
      int b = 200;
      while (cnt < 4 && b > 0) begin
        step();
        b--;
      end
      chk("stream_timeout", cnt >= 4, 1);
    end
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_hold", gf_hold, 1);
    chk("mid_rst_xy", {X, Y}, 0);
    chk("mid_rst_obj", obj_cnt, 0);
    chk("mid_rst_ready", in_ready, 1);
    src.delete(); exp_q.delete();
    cnt = 0; lat = 0; acc_done = 0; pend_acc = 1'b0; freed = 0; exp_obj = 0;
    gf_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    feed_release(pt(500, 600));
    run_until_obj(1);

    // stray result pulse while idle
    gf_valid = 1'b1;
    @(negedge clk) gf_valid = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_hold", gf_hold, 1);
    end
    feed_release(pt(1, 2));
    run_until_obj(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/geofence_feeder.md
# geofence_feeder

Upstream stage of `geofence`. Accepts a point stream over a valid/ready handshake and buffers it in two 7-point ping-pong banks; point 0 of each object is the receiver and points 1..6 are the fence vertices. It then drives `X`/`Y` to `geofence` on the exact 7 consecutive edges where that block samples them. It gates `geofence` through its asynchronous reset (`gf_hold`) whenever no complete object is buffered, and counts returned results.

## Interface
- No parameters; points per object fixed at 7, coordinate width fixed at 10.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream point valid
- in_ready  out  1  feeder can accept a point
- in_x, in_y  in  10  unsigned point coordinates
- X, Y  out  10  registered coordinates to `geofence`
- gf_hold  out  1  registered, drives `geofence` reset; 1 = hold geofence in reset
- gf_valid  in  1  `geofence` result valid (1-cycle pulse)
- obj_cnt  out  8  results received, wraps 255->0
- err  out  1  sticky protocol error

## Operation
- Banks B0/B1, each holding 7 points plus a `full` flag. `wr_bank` and `wr_idx` (0..6) select the write slot; `rd_bank` and `rd_idx` select the read slot.
- A point is accepted on an edge where `in_valid & in_ready`. `in_ready = !full[wr_bank]` (combinational).
- When the accept writes `wr_idx`=6, the feeder sets `full[wr_bank]`, toggles `wr_bank` and clears `wr_idx`.
- Stream FSM states are HOLD, STREAM and WAIT.
- HOLD: `gf_hold`=1. On an edge where `full[rd_bank]`=1, the feeder sets `gf_hold`<=0, drives X/Y<=point 0, sets `rd_idx`<=1 and moves to STREAM.
- STREAM: each edge drives X/Y<=point `rd_idx` and increments `rd_idx`. On the edge driving point 6, the feeder clears `full[rd_bank]`, toggles `rd_bank` and moves to WAIT. `geofence` holds internal copies, so the bank is freed early.
- WAIT: X/Y hold their last value. On an edge with `gf_valid`=1, the feeder increments `obj_cnt`. Then:
  - If `full[rd_bank]`: drive X/Y<=point 0 of that bank, `rd_idx`<=1, go to STREAM; `gf_hold` stays 0.
  - Otherwise: `gf_hold`<=1, go to HOLD.
- If `gf_valid`=1 in HOLD or STREAM, the feeder sets `err`<=1 and ignores the pulse; nothing else changes.
- Coordinates pass through unchanged. There is no arithmetic apart from the counters.

## Timing
- Reset values: `gf_hold`=1, X=Y=0, `obj_cnt`=0, `err`=0, both `full`=0, `wr_bank`=`rd_bank`=0, indices 0, state HOLD. `in_ready` reads 1 while reset is high.
- Sampling contract with `geofence`:
  - After `gf_hold` falls following edge E0, `geofence` samples point k at edge E0+1+k, for k=0..6.
  - After `gf_valid` is seen high at edge Ev, `geofence` samples its next point 0 at Ev+1.
- Fill-to-stream latency: 7th point accepted at edge E, `full` visible at E+1, so `gf_hold` falls and X/Y = point 0 after E+1. `geofence` samples point 0 at E+2.
- Back-to-back objects: zero bubble. X/Y = next receiver after Ev and `gf_hold` never rises.
- Both banks full: `in_ready`=0 until the edge driving point 6 of the streaming bank. `in_ready`=1 in the following cycle.
- Simultaneous bank completion and WAIT exit on the same edge: the FSM uses the pre-edge `full` value. A bank completing at Ev leads to HOLD, then release one edge later.
- Reset mid-operation clears everything immediately. `gf_hold` rises asynchronously, so `geofence` is also reset. Partially written banks are discarded.
- `wr_idx`/`rd_idx` wrap 6->0 only as specified above. Write and read never address the same bank slot concurrently.

## Test plan
- Reset, then 7 back-to-back points (100,100),(50,50),(150,50),(200,100),(150,150),(50,150),(0,100) accepted at edges 1..7 -> `gf_hold` falls after edge 8; X/Y = 100,50,150,200,150,50,0 (x) on edges 9..15; with the `geofence` model, `is_inside`=1 and `obj_cnt`=1.
- 14 continuous points (second receiver (300,300), same fence) -> at the second `gf_valid`, X/Y=(300,300) next cycle and `gf_hold` stays 0; `is_inside`=0 and `obj_cnt`=2.
- 21 continuous points -> `in_ready` low from the cycle after the 14th accept until the cycle after point 6 of object 0 is driven; all 21 points delivered in order.
- Second object delayed 40 cycles after the first result -> `gf_hold`=1 after Ev and held until 1 edge after its 7th accept; X/Y stable while held.
- Reset asserted after point 3 streamed -> `gf_hold`=1 with no clock, X=Y=0, `obj_cnt`=0, `in_ready`=1; next 7 points stream from point 0.
- `gf_valid` pulsed during HOLD -> `err`=1 and stays 1, `obj_cnt` unchanged, state HOLD.
